norm2_pipe: RTL and testbench

Pipelined, parametrised successor to the norm2 kernel. It computes acc + Σ a[i]·a[i] (square mode) or acc + Σ a[i]·b[i] (dot mode) over indices i ∈ [init_i, init_end) from two on-chip sync-read arrays. It sustains one element per cycle. It keeps the r_enable/w_enable start/done handshake and the controlArr host back-door, so it drops into the same top-level harness as the scalar kernel.

---
 rtl/norm2_pkg.sv | 30 +++
 rtl/norm2_ram.sv | 31 +++
 rtl/norm2_pipe.sv | 184 ++++++++++++++++++
 tb/tb_norm2_pipe.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/norm2_pkg.sv
// Shared types, constants and helpers for the norm2_pipe accumulate kernel.
package norm2_pkg;

  // Control states of the accumulate kernel.
  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  // Operand selection for the second multiplier input.
  localparam logic MODE_SQUARE = 1'b0;
  localparam logic MODE_DOT    = 1'b1;

  // Widest value the sign-extension helper handles.
  localparam int EXT_W = 128;

  // Sign-extend the low 'w' bits of 'val' to EXT_W bits.
  // Callers take the width they need with a size cast.
  function automatic logic [EXT_W-1:0] sign_extend(input logic [EXT_W-1:0] val,
                                                   input int              w);
    logic [EXT_W-1:0] upper;
    logic [EXT_W-1:0] shifted;
    upper       = {EXT_W{1'b1}} << w;
    shifted     = val >> (w - 1);
    sign_extend = shifted[0] ? (val | upper) : (val & ~upper);
  endfunction

endpackage

// File: rtl/norm2_ram.sv
// Single-port RAM with synchronous write and registered read address.
// Read data is mem[address captured at the previous clock edge].
module norm2_ram #(
  parameter int DATA_W = 27,
  parameter int ADDR_W = 10
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        addr,
  input  logic signed [DATA_W-1:0] wdata,
  output logic signed [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic signed [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]        addr_q;

  // Write port and read-address register.
  // NOTE: storage arrays carry no reset; only control state is reset, so this
  // maps onto plain block RAM and array contents survive a kernel reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    addr_q <= addr;
  end

  assign rdata = mem[addr_q];

endmodule

// File: rtl/norm2_pipe.sv
// Pipelined square/dot-product accumulator over a[init_i..init_end) with a
// start/done handshake and a host back-door onto the two element arrays.
// Pipeline: issue address -> RAM read (v1) -> multiply (v2) -> accumulate.
module norm2_pipe
  import norm2_pkg::*;
#(
  parameter int DATA_W = 27,
  parameter int ADDR_W = 10,
  parameter int ACC_W  = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     r_enable,
  input  logic [ADDR_W-1:0]        init_i,
  input  logic [ADDR_W:0]          init_end,
  input  logic signed [ACC_W-1:0]  init_acc,
  input  logic                     mode,
  input  logic                     controlArr,
  input  logic                     controlArrWEnable_a,
  input  logic                     controlArrWEnable_b,
  input  logic [ADDR_W-1:0]        controlArrAddr_a,
  input  logic [ADDR_W-1:0]        controlArrAddr_b,
  input  logic signed [DATA_W-1:0] controlArrWData_a,
  input  logic signed [DATA_W-1:0] controlArrWData_b,
  output logic signed [DATA_W-1:0] controlArrRData_a,
  output logic signed [DATA_W-1:0] controlArrRData_b,
  output logic                     w_enable,
  output logic signed [ACC_W-1:0]  result
);

  // Reject parameter sets the accumulator cannot hold.
  generate
    if (ACC_W < 2 * DATA_W) begin : g_acc_too_narrow
      $error("norm2_pipe: ACC_W must be at least 2*DATA_W");
    end
    if (ACC_W > EXT_W || 2 * DATA_W > EXT_W) begin : g_acc_too_wide
      $error("norm2_pipe: ACC_W and 2*DATA_W must not exceed EXT_W");
    end
  endgenerate

  state_t state, state_next;

  logic [ADDR_W:0]            idx;
  logic [ADDR_W:0]            end_idx;
  logic signed [ACC_W-1:0]    acc;
  logic                       mode_q;
  logic                       v1, v2;
  logic signed [2*DATA_W-1:0] prod;
  logic                       issue;
  logic                       drain_done;
  logic                       host_q;

  logic [ADDR_W-1:0]          ram_addr_a, ram_addr_b;
  logic                       ram_we_a, ram_we_b;
  logic signed [DATA_W-1:0]   rd_a, rd_b;
  logic signed [DATA_W-1:0]   mult_b;
  logic signed [2*DATA_W-1:0] prod_d;
  logic [EXT_W-1:0]           prod_wide;

  // Host owns both arrays while controlArr is high; the core only ever reads.
  assign ram_addr_a = controlArr ? controlArrAddr_a : idx[ADDR_W-1:0];
  assign ram_addr_b = controlArr ? controlArrAddr_b : idx[ADDR_W-1:0];
  assign ram_we_a   = controlArr & controlArrWEnable_a;
  assign ram_we_b   = controlArr & controlArrWEnable_b;

  norm2_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram_a (
    .clk   (clk),
    .we    (ram_we_a),
    .addr  (ram_addr_a),
    .wdata (controlArrWData_a),
    .rdata (rd_a)
  );

  norm2_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram_b (
    .clk   (clk),
    .we    (ram_we_b),
    .addr  (ram_addr_b),
    .wdata (controlArrWData_b),
    .rdata (rd_b)
  );

  // Track who owned the arrays when the read address was captured, so host
  // read data is only presented for host-issued reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      host_q <= 1'b0;
    end else begin
      host_q <= controlArr;
    end
  end

  assign controlArrRData_a = host_q ? rd_a : 'x;
  assign controlArrRData_b = host_q ? rd_b : 'x;

  // Full-width signed product; the second operand depends on the latched mode.
  assign mult_b = (mode_q == MODE_DOT) ? rd_b : rd_a;
  assign prod_d = rd_a * mult_b;

  // Zero-pad the product so the helper can sign-extend it to the accumulator.
  always_comb begin
    prod_wide               = '0;
    prod_wide[2*DATA_W-1:0] = prod;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic, element issue and drain completion.
  // NOTE: every output of this block is given a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    drain_done = 1'b0;
    if (r_enable) begin
      state_next = RUN;
    end else begin
      case (state)
        RUN: begin
          if (idx < end_idx) begin
            issue = 1'b1;
          end else begin
            state_next = DRAIN;
          end
        end
        DRAIN: begin
          if (!v1 && !v2) begin
            drain_done = 1'b1;
            state_next = DONE;
          end
        end
        default: state_next = state;
      endcase
    end
  end

  // Datapath: index counter, valid pipeline, multiply, accumulate, result.
  // NOTE: all state here uses non-blocking assignments so every stage samples
  // the previous-cycle value of the stage before it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx      <= '0;
      end_idx  <= '0;
      acc      <= '0;
      mode_q   <= MODE_SQUARE;
      v1       <= 1'b0;
      v2       <= 1'b0;
      prod     <= '0;
      result   <= '0;
      w_enable <= 1'b0;
    end else if (r_enable) begin
      idx      <= {1'b0, init_i};
      end_idx  <= init_end;
      acc      <= init_acc;
      mode_q   <= mode;
      v1       <= 1'b0;
      v2       <= 1'b0;
      w_enable <= 1'b0;
    end else begin
      if (issue) begin
        idx <= idx + (ADDR_W + 1)'(1);
      end
      v1 <= issue;
      v2 <= v1;
      if (v1) begin
        prod <= prod_d;
      end
      if (v2) begin
        acc <= acc + ACC_W'(sign_extend(prod_wide, 2 * DATA_W));
      end
      if (drain_done) begin
        result   <= acc;
        w_enable <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_norm2_pipe.sv
// Self-checking bench for norm2_pipe: directed cases plus randomized runs
// compared against a plain-arithmetic model of the accumulate.
module tb_norm2_pipe;

  localparam int DATA_W = 27;
  localparam int ADDR_W = 10;
  localparam int ACC_W  = 64;
  localparam int DEPTH  = 2 ** ADDR_W;

  logic                     clk;
  logic                     rst;
  logic                     r_enable;
  logic [ADDR_W-1:0]        init_i;
  logic [ADDR_W:0]          init_end;
  logic signed [ACC_W-1:0]  init_acc;
  logic                     mode;
  logic                     controlArr;
  logic                     controlArrWEnable_a, controlArrWEnable_b;
  logic [ADDR_W-1:0]        controlArrAddr_a, controlArrAddr_b;
  logic signed [DATA_W-1:0] controlArrWData_a, controlArrWData_b;
  logic signed [DATA_W-1:0] controlArrRData_a, controlArrRData_b;
  logic                     w_enable;
  logic signed [ACC_W-1:0]  result;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference copies of the array contents, kept as plain integers.
  longint ma [DEPTH];
  longint mb [DEPTH];

  norm2_pipe #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ACC_W(ACC_W)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .r_enable            (r_enable),
    .init_i              (init_i),
    .init_end            (init_end),
    .init_acc            (init_acc),
    .mode                (mode),
    .controlArr          (controlArr),
    .controlArrWEnable_a (controlArrWEnable_a),
    .controlArrWEnable_b (controlArrWEnable_b),
    .controlArrAddr_a    (controlArrAddr_a),
    .controlArrAddr_b    (controlArrAddr_b),
    .controlArrWData_a   (controlArrWData_a),
    .controlArrWData_b   (controlArrWData_b),
    .controlArrRData_a   (controlArrRData_a),
    .controlArrRData_b   (controlArrRData_b),
    .w_enable            (w_enable),
    .result              (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Host writes; each call spans one clock edge.
  task automatic write_a(input int addr, input longint val);
    controlArr          = 1'b1;
    controlArrAddr_a    = ADDR_W'(addr);
    controlArrWData_a   = DATA_W'(val);
    controlArrWEnable_a = 1'b1;
    @(negedge clk);
    controlArrWEnable_a = 1'b0;
    ma[addr] = val;
  endtask

  task automatic write_b(input int addr, input longint val);
    controlArr          = 1'b1;
    controlArrAddr_b    = ADDR_W'(addr);
    controlArrWData_b   = DATA_W'(val);
    controlArrWEnable_b = 1'b1;
    @(negedge clk);
    controlArrWEnable_b = 1'b0;
    mb[addr] = val;
  endtask

  // Pulse r_enable across edge E0; returns at the negedge after E0.
  task automatic start_run(input int ii, input int ie, input longint acc0, input logic md);
    controlArr = 1'b0;
    init_i     = ADDR_W'(ii);
    init_end   = (ADDR_W + 1)'(ie);
    init_acc   = acc0;
    mode       = md;
    r_enable   = 1'b1;
    @(negedge clk);
    r_enable   = 1'b0;
  endtask

  // Count edges after E0 until w_enable, bounded, then check latency and result.
  task automatic wait_check(input string tag, input int exp_lat, input longint exp_res);
    int cnt;
    cnt = 0;
    while (w_enable !== 1'b1 && cnt < 3000) begin
      @(negedge clk);
      cnt++;
    end
    check({tag, " latency"}, cnt, exp_lat);
    check({tag, " result"}, result, exp_res);
  endtask

  // Expected result straight from the definition of the kernel.
  function automatic longint model_sum(input int ii, input int ie, input longint acc0,
                                       input logic md);
    longint s;
    s = acc0;
    for (int i = ii; i < ie; i++) begin
      s += ma[i] * (md ? mb[i] : ma[i]);
    end
    return s;
  endfunction

  function automatic int model_lat(input int ii, input int ie);
    return (ie > ii) ? (ie - ii + 3) : 2;
  endfunction

  task automatic run_check(input string tag, input int ii, input int ie, input longint acc0,
                           input logic md);
    start_run(ii, ie, acc0, md);
    wait_check(tag, model_lat(ii, ie), model_sum(ii, ie, acc0, md));
  endtask

  initial begin
    longint exp;
    rst = 1'b1;
    r_enable = 1'b0;
    init_i = '0;
    init_end = '0;
    init_acc = '0;
    mode = 1'b0;
    controlArr = 1'b0;
    controlArrWEnable_a = 1'b0;
    controlArrWEnable_b = 1'b0;
    controlArrAddr_a = '0;
    controlArrAddr_b = '0;
    controlArrWData_a = '0;
    controlArrWData_b = '0;
    repeat (3) @(negedge clk);
    check("reset w_enable", w_enable, 0);
    check("reset result", result, 0);
    rst = 1'b0;
    @(negedge clk);

    // Square of {3,-4,5}: 50 at E6, then held stable.
    write_a(0, 3);
    write_a(1, -4);
    write_a(2, 5);
    start_run(0, 3, 0, 1'b0);
    wait_check("square3", 6, 50);
    repeat (20) begin
      @(negedge clk);
      check("hold w_enable", w_enable, 1);
      check("hold result", result, 50);
    end

    // Dot with b={2,2,2} on top of 100: 108 at E6.
    write_b(0, 2);
    write_b(1, 2);
    write_b(2, 2);
    start_run(0, 3, 100, 1'b1);
    wait_check("dot3", 6, 108);

    // Empty and inverted ranges finish at E2 with the initial accumulator.
    start_run(5, 5, -7, 1'b0);
    wait_check("empty", 2, -7);
    start_run(9, 4, -7, 1'b1);
    wait_check("inverted", 2, -7);

    // Accumulator wraps from max positive to min negative.
    write_a(0, 1);
    start_run(0, 1, 64'sh7FFF_FFFF_FFFF_FFFF, 1'b0);
    wait_check("wrap", 4, 64'sh8000_0000_0000_0000);

    // Host read-back through the back-door, one cycle of latency.
    write_a(7, -12345);
    write_b(9, 54321);
    controlArr       = 1'b1;
    controlArrAddr_a = ADDR_W'(7);
    controlArrAddr_b = ADDR_W'(9);
    @(negedge clk);
    check("host read a", controlArrRData_a, -12345);
    check("host read b", controlArrRData_b, 54321);

    // Randomized contents over the low 128 entries, then random runs.
    for (int i = 0; i < 128; i++) begin
      write_a(i, longint'($signed(DATA_W'($urandom))));
      write_b(i, longint'($signed(DATA_W'($urandom))));
    end
    for (int k = 0; k < 8; k++) begin
      int ii;
      int ie;
      ii = int'($urandom_range(0, 100));
      ie = int'($urandom_range(0, 127));
      run_check("random", ii, ie, {$urandom, $urandom}, 1'(($urandom % 2)));
    end

    // Restart in the middle of a run: only the second run counts.
    start_run(0, 10, 555, 1'b0);
    repeat (3) @(negedge clk);
    run_check("abort restart", 0, 2, 5, 1'b1);

    // Asynchronous reset in the middle of a run clears outputs at once.
    start_run(0, 10, 0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("async rst w_enable", w_enable, 0);
    check("async rst result", result, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post rst w_enable", w_enable, 0);

    // Full depth of -2**26 squared: 2**62 at E1027.
    for (int i = 0; i < DEPTH; i++) begin
      write_a(i, -(64'sd1 <<< 26));
    end
    exp = 64'sd1 <<< 62;
    start_run(0, DEPTH, 0, 1'b0);
    wait_check("full depth", 1027, exp);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
